// File: rtl/rs_dec_ctrl_if.sv
// Bundle of the rx, core and decoded-stream signals around rs_dec_ctrl.
// The controller uses the slave view; whatever drives it uses master.
interface rs_dec_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 16
);
  logic                  rs_ena;
  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  core_in_vld;
  logic [DATA_WIDTH-1:0] core_in_data;
  logic                  core_sof;
  logic                  core_eof;
  logic                  core_out_vld;
  logic [DATA_WIDTH-1:0] core_out_data;
  logic                  core_out_err;
  logic                  dec_vld;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_isos;
  logic                  RDE_ERROR;
  logic                  busy;
  logic [ERR_CNT_W-1:0]  err_cnt;

  modport slave (
    input  rs_ena, rx_vld, rx_data, core_out_vld, core_out_data, core_out_err,
    output core_in_vld, core_in_data, core_sof, core_eof,
           dec_vld, dec_data, dec_isos, RDE_ERROR, busy, err_cnt
  );

  modport master (
    output rs_ena, rx_vld, rx_data, core_out_vld, core_out_data, core_out_err,
    input  core_in_vld, core_in_data, core_sof, core_eof,
           dec_vld, dec_data, dec_isos, RDE_ERROR, busy, err_cnt
  );
endinterface

// File: rtl/rs_dec_ctrl.sv
// Frames rx beats into RS codewords for the decoder core, strips parity from its output,
// and bypasses the core when rs_ena is low. Define RS_ERR_CNT_EN to build the error counter.
module rs_dec_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CW_BEATS   = 30,
  parameter int PAR_BEATS  = 2,
  parameter int MAX_INFL   = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  rs_dec_ctrl_if.slave  bus
);
  localparam int CNT_W     = $clog2(CW_BEATS);
  localparam int INF_W     = $clog2(MAX_INFL + 1);
  localparam int PAY_BEATS = CW_BEATS - PAR_BEATS;

  typedef enum logic [1:0] {BYPASS, ARM, RUN, DRAIN} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       in_cnt, in_cnt_n, out_cnt, out_cnt_n;
  logic [INF_W-1:0]       infl, infl_n;

  logic                   core_in_vld_q, core_sof_q, core_eof_q;
  logic [DATA_WIDTH-1:0]  core_in_data_q;
  logic                   dec_vld_q, dec_isos_q, rde_q, busy_q;
  logic [DATA_WIDTH-1:0]  dec_data_q;

  logic                   in_vld_n, sof_n, eof_n;
  logic [DATA_WIDTH-1:0]  in_data_n;
  logic                   dec_vld_n, isos_n, rde_n, busy_n;
  logic [DATA_WIDTH-1:0]  dec_data_n;
  logic                   eof_in, wrap_out, payload;
  logic                   out_acc, infl_full;

  // A codeword is outstanding from its sof beat on, so core output may overlap its input.
  assign out_acc   = (state == RUN || state == DRAIN) && bus.core_out_vld &&
                     (infl != '0 || in_cnt != '0);
  assign infl_full = (infl == INF_W'(MAX_INFL));

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n    = state;
    in_cnt_n   = in_cnt;
    out_cnt_n  = out_cnt;
    in_vld_n   = 1'b0;
    sof_n      = 1'b0;
    eof_n      = 1'b0;
    in_data_n  = bus.rx_data;
    dec_vld_n  = 1'b0;
    dec_data_n = dec_data_q;
    isos_n     = 1'b0;
    rde_n      = 1'b0;
    eof_in     = 1'b0;
    wrap_out   = 1'b0;
    payload    = 1'b0;

    unique case (state)
      BYPASS: begin
        dec_vld_n  = bus.rx_vld;
        dec_data_n = bus.rx_data;
        if (bus.rs_ena) state_n = ARM;
      end
      ARM: begin
        if (!bus.rs_ena) begin
          dec_vld_n  = bus.rx_vld;
          dec_data_n = bus.rx_data;
          state_n    = BYPASS;
        end else if (bus.rx_vld) begin
          in_vld_n = 1'b1;
          sof_n    = 1'b1;
          in_cnt_n = CNT_W'(1);
          state_n  = RUN;
        end
      end
      RUN: begin
        if (in_cnt == '0 && !bus.rs_ena) begin
          state_n = DRAIN;
        end else if (bus.rx_vld && !(in_cnt == '0 && infl_full)) begin
          in_vld_n = 1'b1;
          sof_n    = (in_cnt == '0);
          if (in_cnt == CNT_W'(CW_BEATS - 1)) begin
            eof_n    = 1'b1;
            eof_in   = 1'b1;
            in_cnt_n = '0;
            if (!bus.rs_ena) state_n = DRAIN;
          end else begin
            in_cnt_n = in_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (infl == '0 && out_cnt == '0) state_n = BYPASS;
      end
    endcase

    if (out_acc) begin
      payload   = (out_cnt < CNT_W'(PAY_BEATS));
      dec_vld_n = payload;
      if (payload) dec_data_n = bus.core_out_data;
      rde_n     = payload && bus.core_out_err;
      isos_n    = (out_cnt == '0);
      if (out_cnt == CNT_W'(CW_BEATS - 1)) begin
        out_cnt_n = '0;
        wrap_out  = 1'b1;
      end else begin
        out_cnt_n = out_cnt + 1'b1;
      end
    end

    infl_n = infl;
    if (eof_in && !wrap_out)                      infl_n = infl + 1'b1;
    else if (!eof_in && wrap_out && infl != '0)   infl_n = infl - 1'b1;

    busy_n = (infl_n != '0) || (in_cnt_n != '0) || (out_cnt_n != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= BYPASS;
      in_cnt         <= '0;
      out_cnt        <= '0;
      infl           <= '0;
      core_in_vld_q  <= 1'b0;
      core_in_data_q <= '0;
      core_sof_q     <= 1'b0;
      core_eof_q     <= 1'b0;
      dec_vld_q      <= 1'b0;
      dec_data_q     <= '0;
      dec_isos_q     <= 1'b0;
      rde_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_n;
      in_cnt         <= in_cnt_n;
      out_cnt        <= out_cnt_n;
      infl           <= infl_n;
      core_in_vld_q  <= in_vld_n;
      core_in_data_q <= in_data_n;
      core_sof_q     <= sof_n;
      core_eof_q     <= eof_n;
      dec_vld_q      <= dec_vld_n;
      dec_data_q     <= dec_data_n;
      dec_isos_q     <= isos_n;
      rde_q          <= rde_n;
      busy_q         <= busy_n;
    end
  end

  assign bus.core_in_vld  = core_in_vld_q;
  assign bus.core_in_data = core_in_data_q;
  assign bus.core_sof     = core_sof_q;
  assign bus.core_eof     = core_eof_q;
  assign bus.dec_vld      = dec_vld_q;
  assign bus.dec_data     = dec_data_q;
  assign bus.dec_isos     = dec_isos_q;
  assign bus.RDE_ERROR    = rde_q;
  assign bus.busy         = busy_q;

`ifdef RS_ERR_CNT_EN
  logic                 err_hit, ovf_drop;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_n;

  // Error flag is stable per codeword, so its first output beat is the one to count.
  assign err_hit  = out_acc && bus.core_out_err && (out_cnt == '0);
  assign ovf_drop = (state == RUN) && bus.rx_vld && bus.rs_ena && (in_cnt == '0) && infl_full;

  always_comb begin
    err_cnt_n = err_cnt_q;
    if (err_hit  && !(&err_cnt_n)) err_cnt_n = err_cnt_n + 1'b1;
    if (ovf_drop && !(&err_cnt_n)) err_cnt_n = err_cnt_n + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_n;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = {ERR_CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_rs_dec_ctrl.sv
// Directed bench for rs_dec_ctrl: an echoing core with fixed latency, a beat-count reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_rs_dec_ctrl;
  localparam int DW   = 8;
  localparam int CW   = 30;
  localparam int PAR  = 2;
  localparam int MAXI = 4;
  localparam int ECW  = 16;
  localparam int LAT  = 12;
`ifdef RS_ERR_CNT_EN
  localparam int ERR_AFTER_T2 = 1;
`else
  localparam int ERR_AFTER_T2 = 0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rs_dec_ctrl_if #(.DATA_WIDTH(DW), .ERR_CNT_W(ECW)) bus ();

  rs_dec_ctrl #(
    .DATA_WIDTH(DW), .CW_BEATS(CW), .PAR_BEATS(PAR), .MAX_INFL(MAXI), .ERR_CNT_W(ECW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: totals of beats sent into / taken out of the core since reset.
  typedef enum {M_BYP, M_ARM, M_RUN, M_DRAIN} mode_t;
  mode_t m_mode;
  int    n_in, n_out, m_err;
  logic  e_civ, e_sof, e_eof, e_dv, e_isos, e_rde, e_busy;
  logic [DW-1:0] e_cid, e_dd;

  task automatic model_reset();
    m_mode = M_BYP; n_in = 0; n_out = 0; m_err = 0; e_dd = '0;
  endtask

  task automatic model_step();
    mode_t m0  = m_mode;
    int    in0 = n_in;
    int    pos = n_in % CW;
    e_civ = 0; e_sof = 0; e_eof = 0; e_dv = 0; e_isos = 0; e_rde = 0;
    e_cid = bus.rx_data;
    case (m0)
      M_BYP: begin
        e_dv = bus.rx_vld; e_dd = bus.rx_data;
        if (bus.rs_ena) m_mode = M_ARM;
      end
      M_ARM: begin
        if (!bus.rs_ena) begin
          e_dv = bus.rx_vld; e_dd = bus.rx_data; m_mode = M_BYP;
        end else if (bus.rx_vld) begin
          e_civ = 1; e_sof = 1; n_in++; m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (pos == 0 && !bus.rs_ena) m_mode = M_DRAIN;
        else if (bus.rx_vld) begin
          if (pos == 0 && (n_in / CW - n_out / CW) == MAXI) m_err++;
          else begin
            e_civ = 1; e_sof = (pos == 0); e_eof = (pos == CW - 1); n_in++;
            if (e_eof && !bus.rs_ena) m_mode = M_DRAIN;
          end
        end
      end
      M_DRAIN: if (n_in == n_out) m_mode = M_BYP;
    endcase
    if ((m0 == M_RUN || m0 == M_DRAIN) && bus.core_out_vld &&
        (in0 + CW - 1) / CW > n_out / CW) begin
      int opos;
      opos   = n_out % CW;
      e_dv   = (opos < CW - PAR);
      if (e_dv) e_dd = bus.core_out_data;
      e_rde  = e_dv && bus.core_out_err;
      e_isos = (opos == 0);
      if (opos == 0 && bus.core_out_err) m_err++;
      n_out++;
    end
    e_busy = (n_in != n_out);
  endtask

  function automatic logic [ECW-1:0] exp_err(input int n);
`ifdef RS_ERR_CNT_EN
    return ECW'(n);
`else
    return ECW'(n * 0);
`endif
  endfunction

  // Echoing core: fixed latency, error flag chosen per codeword by the bench.
  logic          pv[LAT];
  logic [DW-1:0] pd[LAT];
  logic          pe[LAT];
  logic          cur_err;
  int            sof_total, err_cw;

  task automatic core_flush();
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = '0; pe[i] = 0; end
    cur_err = 0;
  endtask

  // Per-scenario statistics
  int cyc_no, fwd_idx, n_civ, n_dv, n_isos, n_rde, eof_cyc;
  int sof_pos[$], eof_pos[$];

  task automatic reset_stats();
    cyc_no = 0; fwd_idx = 0; n_civ = 0; n_dv = 0; n_isos = 0; n_rde = 0; eof_cyc = -1;
    sof_pos.delete(); eof_pos.delete();
  endtask

  task automatic cyc(input logic ena, input logic vld, input logic [DW-1:0] data);
    bus.rs_ena        = ena;
    bus.rx_vld        = vld;
    bus.rx_data       = data;
    bus.core_out_vld  = pv[LAT-1];
    bus.core_out_data = pd[LAT-1];
    bus.core_out_err  = pe[LAT-1];
    model_step();
    @(posedge clk); #1;
    cyc_no++;
    check("core_in_vld", bus.core_in_vld, e_civ);
    if (e_civ) check("core_in_data", bus.core_in_data, e_cid);
    check("core_sof", bus.core_sof, e_sof);
    check("core_eof", bus.core_eof, e_eof);
    check("dec_vld", bus.dec_vld, e_dv);
    if (e_dv) check("dec_data", bus.dec_data, e_dd);
    check("dec_isos", bus.dec_isos, e_isos);
    check("RDE_ERROR", bus.RDE_ERROR, e_rde);
    check("busy", bus.busy, e_busy);
    check("err_cnt", bus.err_cnt, exp_err(m_err));
    if (bus.core_in_vld) begin
      if (bus.core_sof) begin
        sof_pos.push_back(fwd_idx);
        cur_err = (sof_total == err_cw);
        sof_total++;
      end
      if (bus.core_eof) begin eof_pos.push_back(fwd_idx); eof_cyc = cyc_no; end
      fwd_idx++; n_civ++;
    end
    if (bus.dec_vld)   n_dv++;
    if (bus.dec_isos)  n_isos++;
    if (bus.RDE_ERROR) n_rde++;
    for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; pe[i] = pe[i-1]; end
    pv[0] = bus.core_in_vld; pd[0] = bus.core_in_data; pe[0] = cur_err;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core"}, {bus.core_in_vld, bus.core_in_data, bus.core_sof, bus.core_eof}, 0);
    check({tag, "_dec"}, {bus.dec_vld, bus.dec_data, bus.dec_isos, bus.RDE_ERROR, bus.busy}, 0);
    check({tag, "_err"}, bus.err_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.rs_ena = 0; bus.rx_vld = 1; bus.rx_data = 8'hA5;
    bus.core_out_vld = 0; bus.core_out_data = '0; bus.core_out_err = 0;
    core_flush(); model_reset(); reset_stats();
    sof_total = 0; err_cw = -1;
    #12;
    check_reset("reset");
    #10 rstn = 1'b1;

    // Bypass: one-cycle registered copy of rx
    cyc(0, 1, 8'hA5);
    check("byp_vld", bus.dec_vld, 1);
    check("byp_data", bus.dec_data, 8'hA5);
    check("byp_core_idle", {bus.core_in_vld, bus.dec_isos}, 0);
    cyc(0, 0, 8'h11);
    cyc(0, 1, 8'h5A);

    // Two contiguous codewords, the second one uncorrectable
    cyc(1, 0, 8'h00);
    reset_stats();
    err_cw = sof_total + 1;
    for (int i = 0; i < 2 * CW; i++) cyc(1, 1, DW'(i + 1));
    for (int i = 0; i < 25; i++) cyc(1, 0, 8'h00);
    check("t2_sof_n", sof_pos.size(), 2);
    check("t2_eof_n", eof_pos.size(), 2);
    if (sof_pos.size() == 2) begin
      check("t2_sof0", sof_pos[0], 0);
      check("t2_sof1", sof_pos[1], 30);
    end
    if (eof_pos.size() == 2) begin
      check("t2_eof0", eof_pos[0], 29);
      check("t2_eof1", eof_pos[1], 59);
    end
    check("t2_dec_vld_n", n_dv, 56);
    check("t2_isos_n", n_isos, 2);
    check("t2_rde_n", n_rde, 28);
    check("t2_err_cnt", bus.err_cnt, ERR_AFTER_T2);
    err_cw = -1;

    // rs_ena drops at beat 10: codeword completes, later beats dropped, then drain
    reset_stats();
    for (int i = 0; i < 35; i++) cyc(i < 10, 1, DW'(8'h40 + i));
    check("t3_fwd_n", n_civ, 30);
    check("t3_eof_n", eof_pos.size(), 1);
    if (eof_pos.size() == 1) check("t3_eof_pos", eof_pos[0], 29);
    for (int k = 0; k < 100 && bus.busy; k++) cyc(0, 0, 8'h00);
    check("t3_busy_fell", bus.busy, 0);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h3C);
    check("t3_bypass_vld", bus.dec_vld, 1);
    check("t3_bypass_data", bus.dec_data, 8'h3C);

    // rx_vld toggling every cycle for one codeword
    cyc(1, 0, 8'h00);
    reset_stats();
    for (int i = 1; i <= 2 * CW; i++) cyc(1, i[0], DW'(i));
    check("t4_fwd_n", n_civ, 30);
    check("t4_eof_cycle", eof_cyc, 59);
    for (int i = 0; i < 25; i++) cyc(1, 0, 8'h00);

    // Async reset at input beat 15, then restart from ARM
    reset_stats();
    for (int i = 0; i < 15; i++) cyc(1, 1, DW'(8'h80 + i));
    #2 rstn = 1'b0;
    bus.rx_vld = 0;
    #1;
    check_reset("async_rst");
    model_reset(); core_flush();
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h77);
    check("t5_sof", bus.core_sof, 1);
    check("t5_in_vld", bus.core_in_vld, 1);
    check("t5_in_data", bus.core_in_data, 8'h77);
    for (int i = 0; i < 4; i++) cyc(1, 1, DW'(8'h78 + i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
